// File: rtl/pixel_render.sv
// rtl/pixel_render.sv - full-frame tile renderer feeding a VGA adapter write port
// Scans 160x120 pixels, looks up 16x16 tiles in map RAM, and emits one plot per pixel.
module pixel_render (
  input  logic       clk50M,
  input  logic       rst_n,
  input  logic       redraw_req,
  output logic       point_cnt_en,
  input  logic [7:0] x,
  input  logic [6:0] y,
  output logic [6:0] map_addr,
  input  logic [2:0] map_data,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SCAN  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;
  localparam logic [7:0] X_LAST   = 8'd159;
  localparam logic [6:0] Y_LAST   = 7'd119;

  logic [1:0] state_q, state_d;
  logic       pending_q, pending_d;
  logic       flush_q, flush_d;
  logic       done_q, done_d;
  logic       en_q, busy_q;

  logic [7:0] s1_x_q;
  logic [6:0] s1_y_q;
  logic       s1_valid_q, s1_band_q;

  logic [7:0] vga_x_q;
  logic [6:0] vga_y_q;
  logic [2:0] colour_q, colour_d;
  logic       plot_q;

  logic [2:0] tile_row;
  logic [3:0] tile_col;
  logic       band;

  // Row 7 of tiles (y >= 112) is the status band: no map cell behind it.
  assign tile_row = y[6:4];
  assign tile_col = x[7:4];
  assign band     = (tile_row == 3'd7);
  assign map_addr = band ? 7'd0
                  : ({1'b0, tile_row, 3'b000} + {3'b000, tile_row, 1'b0} + {3'b000, tile_col});

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    flush_d   = flush_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redraw_req || pending_q) begin
          state_d   = ST_SCAN;
          pending_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (redraw_req) pending_d = 1'b1;
        if (x == X_LAST && y == Y_LAST) begin
          state_d = ST_FLUSH;
          flush_d = 1'b0;
        end
      end
      ST_FLUSH: begin
        if (redraw_req) pending_d = 1'b1;
        if (flush_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  logic [3:0] px, py;
  logic       border, centre;

  assign px     = s1_x_q[3:0];
  assign py     = s1_y_q[3:0];
  assign border = (px == 4'd0) || (px == 4'd15) || (py == 4'd0) || (py == 4'd15);
  assign centre = (px >= 4'd6) && (px <= 4'd9) && (py >= 4'd6) && (py <= 4'd9);

  // map_data arrives aligned with stage 1, so colour is decoded from stage-1 position.
  always_comb begin
    colour_d = 3'b000;
    if (!s1_band_q) begin
      case (map_data)
        3'd0: colour_d = 3'b000;
        3'd1: colour_d = 3'b100;
        3'd2: colour_d = border ? 3'b111 : 3'b110;
        3'd3: colour_d = centre ? 3'b001 : 3'b000;
        3'd4: colour_d = border ? 3'b010 : 3'b110;
        3'd5: colour_d = 3'b011;
        3'd6: colour_d = centre ? 3'b001 : 3'b011;
        3'd7: colour_d = 3'b101;
      endcase
    end
  end

  always_ff @(posedge clk50M) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pending_q  <= 1'b0;
      flush_q    <= 1'b0;
      done_q     <= 1'b0;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      s1_x_q     <= 8'd0;
      s1_y_q     <= 7'd0;
      s1_valid_q <= 1'b0;
      s1_band_q  <= 1'b0;
      vga_x_q    <= 8'd0;
      vga_y_q    <= 7'd0;
      colour_q   <= 3'b000;
      plot_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pending_q  <= pending_d;
      flush_q    <= flush_d;
      done_q     <= done_d;
      en_q       <= (state_d == ST_SCAN);
      busy_q     <= (state_d != ST_IDLE);
      s1_x_q     <= x;
      s1_y_q     <= y;
      s1_valid_q <= en_q;
      s1_band_q  <= band;
      plot_q     <= s1_valid_q;
      if (s1_valid_q) begin
        vga_x_q  <= s1_x_q;
        vga_y_q  <= s1_y_q;
        colour_q <= colour_d;
      end
    end
  end

  assign point_cnt_en = en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign vga_x        = vga_x_q;
  assign vga_y        = vga_y_q;
  assign colour       = colour_q;
  assign plot         = plot_q;

endmodule
